imem_fetch_responder: RTL and testbench

Instruction-memory responder for the fetch path: the slave end of the program-counter fetch interface. It accepts one byte-addressed fetch request at a time from the PC/next-PC logic and returns the 32-bit instruction word after a fixed, parameterised number of wait states, using a valid/ready handshake on both request and response. A separate load port writes program words into the internal array. The block sits between the `pc` register output and the instruction decoder.

---
 rtl/imem_fetch_responder_if.sv | 34 +++
 rtl/imem_fetch_responder.sv | 111 +++++++++++
 tb/tb_imem_fetch_responder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response bus between the PC logic (master) and the
// instruction memory responder (slave).
interface imem_fetch_responder_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic              rsp_err;

    modport master (
        output req_valid,
        output req_addr,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_instr,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_instr,
        output rsp_err
    );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction memory responder: one outstanding fetch at a time, fixed wait
// states, valid/ready on request and response, plus a word load port.
module imem_fetch_responder #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    imem_fetch_responder_if.slave bus,
    input  logic                load_en,
    input  logic [ADDR_W-3:0]   load_addr,
    input  logic [DATA_W-1:0]   load_data,
    output logic                busy
);
    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [3:0]        wait_cnt;
    logic [IDX_W-1:0]  lat_idx;
    logic              lat_mis;
    logic [DATA_W-1:0] rsp_instr_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              enter_resp;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_mis;

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd1) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // With zero wait states the read happens on the accepting edge itself,
    // before the index register has been loaded.
    assign enter_resp = (next_state == ST_RESP) && (state != ST_RESP);
    assign rd_idx     = accept ? bus.req_addr[ADDR_W-1:2] : lat_idx;
    assign rd_mis     = accept ? (bus.req_addr[1:0] != 2'b00) : lat_mis;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= 4'd0;
            lat_idx     <= '0;
            lat_mis     <= 1'b0;
            rsp_instr_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                lat_idx  <= bus.req_addr[ADDR_W-1:2];
                lat_mis  <= (bus.req_addr[1:0] != 2'b00);
                wait_cnt <= 4'(WAIT_CYCLES);
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (enter_resp) begin
                rsp_instr_q <= rd_mis ? '0 : mem[rd_idx];
                rsp_err_q   <= rd_mis;
            end
        end
    end

    // A load on the RESP-entry edge lands after the read above, so the
    // response sees the old word while the array takes the new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_instr = rsp_instr_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: one DUT with two wait states and a
// second with zero wait states sharing clock, reset and load port.
module tb_imem_fetch_responder;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              load_en;
    logic [ADDR_W-3:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              busy;
    logic              busy0;

    int passed;
    int total;

    imem_fetch_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    imem_fetch_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();

    imem_fetch_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .busy      (busy)
    );

    imem_fetch_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus0.slave),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .busy      (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [ADDR_W-3:0] idx, input logic [DATA_W-1:0] data);
        load_en   = 1'b1;
        load_addr = idx;
        load_data = data;
        tick();
        load_en = 1'b0;
    endtask

    // Fetch on the 2-wait DUT with rsp_ready high; lat counts cycles from the
    // accepting edge until rsp_valid is seen, then the handshake completes.
    task automatic do_fetch(input logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] instr,
                            output logic err, output int lat);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        instr = bus.rsp_instr;
        err   = bus.rsp_err;
        tick();
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] instr;
        logic              err;
        int                lat;
        rst       = 1'b1;
        load_en   = 1'b1;
        load_addr = 3'd3;
        load_data = 32'hABCD1234;
        tick();
        rst     = 1'b0;
        load_en = 1'b0;
        total++; if (bus.req_ready !== 1'b1) $display("[TB] FAIL reset_req_ready: got %b expected 1", bus.req_ready); else passed++;
        total++; if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); else passed++;
        total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (bus.rsp_instr !== 32'h0 || bus.rsp_err !== 1'b0)
            $display("[TB] FAIL reset_rsp_regs: got %h/%b expected 00000000/0", bus.rsp_instr, bus.rsp_err); else passed++;
        do_fetch(5'd12, instr, err, lat);
        total++; if (instr !== 32'h00000000) $display("[TB] FAIL reset_word3: got %h expected 00000000", instr); else passed++;
    endtask

    task automatic test_aligned_fetch();
        logic [DATA_W-1:0] instr;
        logic              err;
        int                lat;
        load_word(3'd1, 32'h8C220004);
        do_fetch(5'd4, instr, err, lat);
        total++; if (lat !== 3) $display("[TB] FAIL aligned_latency: got %0d expected 3", lat); else passed++;
        total++; if (instr !== 32'h8C220004) $display("[TB] FAIL aligned_instr: got %h expected 8c220004", instr); else passed++;
        total++; if (err !== 1'b0) $display("[TB] FAIL aligned_err: got %b expected 0", err); else passed++;
        total++; if (bus.req_ready !== 1'b1 || busy !== 1'b0)
            $display("[TB] FAIL aligned_return_idle: got ready=%b busy=%b expected 1/0", bus.req_ready, busy); else passed++;
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] instr;
        logic              err;
        int                lat;
        load_word(3'd2, 32'h33333333);
        bus.req_valid = 1'b1;
        bus.req_addr  = 5'd4;
        bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        total++; if (lat !== 3) $display("[TB] FAIL bp_latency: got %0d expected 3", lat); else passed++;
        bus.req_valid = 1'b1;
        bus.req_addr  = 5'd8;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_instr !== 32'h8C220004 || bus.req_ready !== 1'b0)
                $display("[TB] FAIL bp_hold_%0d: got valid=%b instr=%h ready=%b expected 1/8c220004/0",
                         i, bus.rsp_valid, bus.rsp_instr, bus.req_ready);
            else passed++;
        end
        bus.rsp_ready = 1'b1;
        tick();
        total++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
            $display("[TB] FAIL bp_release: got valid=%b ready=%b expected 0/1", bus.rsp_valid, bus.req_ready); else passed++;
        do_fetch(5'd8, instr, err, lat);
        total++; if (instr !== 32'h33333333 || lat !== 3)
            $display("[TB] FAIL bp_second_req: got %h lat %0d expected 33333333 lat 3", instr, lat); else passed++;
    endtask

    task automatic test_misaligned();
        logic [DATA_W-1:0] instr;
        logic              err;
        int                lat;
        do_fetch(5'd6, instr, err, lat);
        total++; if (err !== 1'b1) $display("[TB] FAIL mis_err: got %b expected 1", err); else passed++;
        total++; if (instr !== 32'h0) $display("[TB] FAIL mis_instr: got %h expected 00000000", instr); else passed++;
        total++; if (lat !== 3) $display("[TB] FAIL mis_latency: got %0d expected 3", lat); else passed++;
        do_fetch(5'd4, instr, err, lat);
        total++; if (instr !== 32'h8C220004 || err !== 1'b0)
            $display("[TB] FAIL mis_mem_intact: got %h/%b expected 8c220004/0", instr, err); else passed++;
    endtask

    task automatic test_load_read();
        logic [DATA_W-1:0] instr;
        logic              err;
        int                lat;
        load_word(3'd2, 32'h11111111);
        bus.req_valid = 1'b1;
        bus.req_addr  = 5'd8;
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        load_word(3'd2, 32'h22222222);
        lat = 2;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        total++; if (bus.rsp_instr !== 32'h22222222 || lat !== 3)
            $display("[TB] FAIL load_in_wait: got %h lat %0d expected 22222222 lat 3", bus.rsp_instr, lat); else passed++;
        tick();

        load_word(3'd2, 32'h11111111);
        bus.req_valid = 1'b1;
        bus.req_addr  = 5'd8;
        bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        tick();
        load_word(3'd2, 32'h22222222);
        total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_instr !== 32'h11111111)
            $display("[TB] FAIL load_collide: got valid=%b instr=%h expected 1/11111111", bus.rsp_valid, bus.rsp_instr); else passed++;
        load_word(3'd2, 32'h55555555);
        total++; if (bus.rsp_instr !== 32'h11111111)
            $display("[TB] FAIL load_in_resp_hold: got %h expected 11111111", bus.rsp_instr); else passed++;
        bus.rsp_ready = 1'b1;
        tick();
        do_fetch(5'd8, instr, err, lat);
        total++; if (instr !== 32'h55555555)
            $display("[TB] FAIL load_after_collide: got %h expected 55555555", instr); else passed++;
    endtask

    task automatic test_reset_midflight();
        logic [DATA_W-1:0] instr;
        logic              err;
        int                lat;
        int                seen;
        bus.req_valid = 1'b1;
        bus.req_addr  = 5'd4;
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        total++; if (busy !== 1'b1) $display("[TB] FAIL mid_busy_wait: got %b expected 1", busy); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0) $display("[TB] FAIL mid_busy_after_rst: got %b expected 0", busy); else passed++;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.rsp_valid === 1'b1) seen++;
            tick();
        end
        total++; if (seen !== 0) $display("[TB] FAIL mid_no_rsp: got %0d valid cycles expected 0", seen); else passed++;
        do_fetch(5'd4, instr, err, lat);
        total++; if (instr !== 32'h0) $display("[TB] FAIL mid_mem_cleared: got %h expected 00000000", instr); else passed++;
    endtask

    task automatic test_wait_zero();
        load_word(3'd0, 32'hDEADBEEF);
        bus0.req_valid = 1'b1;
        bus0.req_addr  = 5'd0;
        bus0.rsp_ready = 1'b1;
        tick();
        bus0.req_valid = 1'b0;
        total++; if (bus0.rsp_valid !== 1'b1 || bus0.rsp_instr !== 32'hDEADBEEF)
            $display("[TB] FAIL w0_response: got valid=%b instr=%h expected 1/deadbeef", bus0.rsp_valid, bus0.rsp_instr); else passed++;
        tick();
        total++; if (bus0.req_ready !== 1'b1 || busy0 !== 1'b0)
            $display("[TB] FAIL w0_return_idle: got ready=%b busy=%b expected 1/0", bus0.req_ready, busy0); else passed++;
    endtask

    initial begin
        passed         = 0;
        total          = 0;
        rst            = 1'b0;
        load_en        = 1'b0;
        load_addr      = '0;
        load_data      = '0;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.rsp_ready  = 1'b1;
        bus0.req_valid = 1'b0;
        bus0.req_addr  = '0;
        bus0.rsp_ready = 1'b1;
        tick();
        test_reset();
        test_aligned_fetch();
        test_backpressure();
        test_misaligned();
        test_load_read();
        test_reset_midflight();
        test_wait_zero();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
